mio_responder: RTL
==================

MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256: internal RAM depth in 32-bit words, power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between acceptance and response, range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 CPU_MIO  input  1  bus request from CPU, level.
REQ-006 mem_w  input  1  1 = write, 0 = read; sampled at acceptance.
REQ-007 Addr_in  input  32  byte address; sampled at acceptance.
REQ-008 Data_in  input  32  write data from CPU; sampled at acceptance.
REQ-009 Data_out  output  32  read data to CPU.
REQ-010 MIO_ready  output  1  one-cycle completion pulse.
REQ-011 gpio_out  output  32  GPIO register contents.

Function
REQ-012 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-013 IDLE with CPU_MIO=1: request accepted; mem_w, Addr_in, Data_in latched; next state WAIT, or RESP if WAIT_CYCLES=0.
REQ-014 WAIT: internal counter loaded with WAIT_CYCLES-1 at acceptance, decrements each cycle; moves to RESP when counter is 0, giving exactly WAIT_CYCLES WAIT cycles.
REQ-015 RESP: MIO_ready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-016 MIO_ready=0 in IDLE and WAIT; no two pulses closer than 2 cycles.
REQ-017 CPU_MIO still high in the IDLE cycle after RESP is a new request (back-to-back allowed).
REQ-018 Input changes after acceptance ignored until the next acceptance.
REQ-019 Writes and read captures take effect on the edge entering RESP; Data_out valid in RESP and held until the next RESP capture.
REQ-020 Write transactions leave Data_out unchanged.
REQ-021 Address decode ignores Addr[1:0].
REQ-022 Addr[31:28]=0x0: RAM, word index Addr[log2(RAM_WORDS)+1:2]; higher bits in the region ignored, so the region aliases.
REQ-023 0xF000_0000: GPIO, read/write.
REQ-024 0xF000_0004: free-running cycle counter, read-only; writes dropped.
REQ-025 0xF000_0008: error counter, read-only; writes dropped.
REQ-026 Any other address: read returns 32'h0, write dropped; error counter increments; a response is still given.
REQ-027 Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF -> 0; a read returns the value before the increment on the capture edge.
REQ-028 Error counter: 32-bit, saturates at 0xFFFF_FFFF.

Reset
REQ-029 Reset forces IDLE, MIO_ready=0, Data_out=0, gpio_out=0, cycle counter=0, error counter=0, wait counter=0.
REQ-030 Reset during WAIT or RESP aborts the transaction: pending write not performed, no MIO_ready pulse.
REQ-031 RAM contents are not reset.
REQ-032 Reset has priority over a request in the same cycle.

Structure
REQ-033 Package mio_pkg holds: state enum; region base constants 0x0 and 0xF; offsets GPIO=0x0, CYC=0x4, ERR=0x8.
REQ-034 Sub-module mio_ram: single-port synchronous RAM, RAM_WORDS x 32, write enable, registered read; instantiated once.
REQ-035 FSM, decode, registers and counters are in mio_responder.

Verification
REQ-036 WAIT_CYCLES=2; write 0x1234_5678 to 0x0000_0010, then read it -> each MIO_ready pulse 3 cycles after acceptance; read Data_out=0x1234_5678.
REQ-037 WAIT_CYCLES=0; write 0xA5A5_0001 to 0xF000_0000 -> MIO_ready 1 cycle after acceptance; gpio_out=0xA5A5_0001 from RESP onward.
REQ-038 Read 0x1234_0000 -> Data_out=0; error counter reads 1 at 0xF000_0008; write to 0xF000_0004 leaves the counter running.
REQ-039 CPU_MIO held high across 3 requests -> pulses spaced exactly WAIT_CYCLES+2 cycles apart; Addr_in changed mid-WAIT has no effect.
REQ-040 Reset asserted during WAIT of a write to 0x0000_0020 -> no pulse; later read of 0x0000_0020 returns the old value; outputs at reset values.
REQ-041 Force cycle counter to 0xFFFF_FFFE, read twice back-to-back -> wrap observed, values consistent with REQ-027.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared types, address map constants and the address decoder for mio_responder.
package mio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } mio_state_e;

    // Which resource a transaction addresses.
    typedef enum logic [2:0] {
        TgtNone,
        TgtRam,
        TgtGpio,
        TgtCyc,
        TgtErr
    } mio_tgt_e;

    // Region is selected by Addr[31:28].
    localparam logic [3:0]  RegionRam = 4'h0;
    localparam logic [3:0]  RegionIo  = 4'hF;

    // Offsets inside the I/O region.
    localparam logic [27:0] OffGpio   = 28'h000_0000;
    localparam logic [27:0] OffCyc    = 28'h000_0004;
    localparam logic [27:0] OffErr    = 28'h000_0008;

    // Decode a word address; byte-lane bits are never looked at.
    function automatic mio_tgt_e mio_decode(input logic [31:2] word_addr);
        mio_tgt_e tgt;
        tgt = TgtNone;
        if (word_addr[31:28] == RegionRam) begin
            tgt = TgtRam;
        end else if (word_addr[31:28] == RegionIo) begin
            if (word_addr[27:2] == OffGpio[27:2]) begin
                tgt = TgtGpio;
            end else if (word_addr[27:2] == OffCyc[27:2]) begin
                tgt = TgtCyc;
            end else if (word_addr[27:2] == OffErr[27:2]) begin
                tgt = TgtErr;
            end
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous RAM with write enable and a registered, enable-gated read port.
module mio_ram #(
    parameter int unsigned Words = 256,
    localparam int unsigned AddrW = $clog2(Words)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [Words];
    logic [31:0] rdata_q, rdata_d;

    // Read register only moves on a read, so the last read word is held.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    // Storage and read register; contents deliberately have no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: request FSM with wait states, RAM, GPIO and counters.
module mio_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_WORDS   = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic [31:0] gpio_out
);

    localparam int unsigned RamAw   = $clog2(RAM_WORDS);
    localparam bit          NoWait  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CntLoad = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mio_state_e  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        req_w_q, req_w_d;
    logic [31:2] req_addr_q, req_addr_d;
    logic [31:0] req_data_q, req_data_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_ram_q, rd_ram_d;

    logic        txn_w;
    logic [31:2] txn_addr;
    logic [31:0] txn_data;
    mio_tgt_e    txn_tgt;
    logic        commit;
    logic        ram_we, ram_re;
    logic [31:0] ram_rdata;

    // Byte-lane address bits play no part in decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Addr_in[1:0];

    // Transaction being completed: live inputs when going straight from IDLE to RESP.
    always_comb begin
        if (state_q == StIdle) begin
            txn_w    = mem_w;
            txn_addr = Addr_in[31:2];
            txn_data = Data_in;
        end else begin
            txn_w    = req_w_q;
            txn_addr = req_addr_q;
            txn_data = req_data_q;
        end
        txn_tgt = mio_decode(txn_addr);
    end

    // Request FSM: acceptance, wait-state countdown, one-cycle response.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_w_d    = req_w_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        commit     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CPU_MIO) begin
                    req_w_d    = mem_w;
                    req_addr_d = Addr_in[31:2];
                    req_data_d = Data_in;
                    wait_cnt_d = CntLoad;
                    if (NoWait) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // RAM accesses happen on the edge entering RESP; reset on that edge cancels them.
    always_comb begin
        ram_we = commit && !reset && (txn_tgt == TgtRam) && txn_w;
        ram_re = commit && !reset && (txn_tgt == TgtRam) && !txn_w;
    end

    mio_ram #(
        .Words (RAM_WORDS)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (txn_addr[RamAw+1:2]),
        .wdata_i (txn_data),
        .rdata_o (ram_rdata)
    );

    // Register-side effects of a completing transaction, plus the free-running counter.
    always_comb begin
        gpio_d    = gpio_q;
        err_cnt_d = err_cnt_q;
        rd_data_d = rd_data_q;
        rd_ram_d  = rd_ram_q;
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        if (commit) begin
            unique case (txn_tgt)
                TgtRam: begin
                    if (!txn_w) begin
                        rd_ram_d = 1'b1;
                    end
                end
                TgtGpio: begin
                    if (txn_w) begin
                        gpio_d = txn_data;
                    end else begin
                        rd_data_d = gpio_q;
                        rd_ram_d  = 1'b0;
                    end
                end
                TgtCyc: begin
                    if (!txn_w) begin
                        rd_data_d = cyc_cnt_q;
                        rd_ram_d  = 1'b0;
                    end
                end
                TgtErr: begin
                    if (!txn_w) begin
                        rd_data_d = err_cnt_q;
                        rd_ram_d  = 1'b0;
                    end
                end
                TgtNone: begin
                    if (err_cnt_q != 32'hFFFF_FFFF) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                    end
                    if (!txn_w) begin
                        rd_data_d = 32'h0;
                        rd_ram_d  = 1'b0;
                    end
                end
                default: begin
                    rd_ram_d = rd_ram_q;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            req_w_q    <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= 32'h0;
            gpio_q     <= 32'h0;
            cyc_cnt_q  <= 32'h0;
            err_cnt_q  <= 32'h0;
            rd_data_q  <= 32'h0;
            rd_ram_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_w_q    <= req_w_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            gpio_q     <= gpio_d;
            cyc_cnt_q  <= cyc_cnt_d;
            err_cnt_q  <= err_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_ram_q   <= rd_ram_d;
        end
    end

    // RAM reads are returned straight from the RAM read register, which holds its value.
    assign Data_out  = rd_ram_q ? ram_rdata : rd_data_q;
    assign MIO_ready = (state_q == StResp);
    assign gpio_out  = gpio_q;

endmodule
